lamp_guard: RTL and testbench
=============================

LAMP_GUARD -- requirements
Module: lamp_guard

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 16, maximum consecutive cycles an identical (lightsA, lightsB) pair is accepted.
REQ-002 SHALL have parameter FLASH_HALF, default 4, half-period in cycles of fault-mode amber flashing.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port lightsA  input  3  road A lamp request from the light sequencer: bit2 red, bit1 amber, bit0 green.
REQ-006 SHALL have port lightsB  input  3  road B lamp request, same encoding.
REQ-007 SHALL have port lampsA  output  3  registered road A lamp drive, same encoding.
REQ-008 SHALL have port lampsB  output  3  registered road B lamp drive, same encoding.
REQ-009 SHALL have port fault  output  1  sticky fault flag.
REQ-010 SHALL have port fault_code  output  3  cause of first fault: 001 illegal pattern, 010 conflict, 011 illegal transition, 100 stuck, 000 none.

Function
REQ-011 SHALL implement states INIT (no prior sample), RUN and FAULT.
REQ-012 SHALL treat 100 (red), 110 (red+amber), 001 (green) and 010 (amber) as the only legal per-road patterns; any other value is an illegal pattern.
REQ-013 SHALL flag a conflict when neither lightsA nor lightsB equals 100 in the same cycle.
REQ-014 SHALL accept per-road transitions only as hold or 100->110, 110->001, 001->010, 010->100; any other change is an illegal transition.
REQ-015 SHALL skip the transition check in INIT; INIT moves to RUN after one fault-free sample.
REQ-016 SHALL keep a hold counter: set to 1 on any sample differing from the previous one (and in INIT), incremented otherwise, saturating at MAX_HOLD+1.
REQ-017 SHALL flag stuck when the same pair is presented for MAX_HOLD+1 consecutive samples.
REQ-018 SHALL prioritise simultaneous detections as pattern > conflict > transition > stuck and latch only the highest.
REQ-019 SHALL, in INIT/RUN with no fault detected on the sample of cycle N, drive lampsA/lampsB at cycle N+1 equal to lightsA/lightsB of cycle N (one-cycle latency).
REQ-020 SHALL, on a fault detected at cycle N, enter FAULT with fault=1 and fault_code latched at cycle N+1; the faulty pattern is never driven to lamps.
REQ-021 SHALL, in FAULT, drive both roads 010 for FLASH_HALF cycles then 000 for FLASH_HALF cycles, repeating, starting with 010 at the first FAULT cycle, irrespective of inputs.
REQ-022 SHALL remain in FAULT, with fault and fault_code unchanged, until rst.
REQ-023 SHALL size the hold counter and flash counter from their parameters so neither wraps.

Reset
REQ-024 SHALL, with rst high at a rising edge, set state INIT, lampsA=100, lampsB=100, fault=0, fault_code=000 and clear all counters, regardless of current state.
REQ-025 SHALL give rst priority over every detection in the same cycle, including reset asserted mid-flash.

Verification
REQ-026 SHALL cover: reset, then pairs A/B 100/110, 100/001, 100/010, 100/100, 110/100, 001/100, 010/100, 100/100 repeated 3 times -> lamps echo inputs one cycle later, fault=0 throughout.
REQ-027 SHALL cover: in RUN apply A=001, B=001 -> next cycle fault=1, fault_code=010, lamps 010/010.
REQ-028 SHALL cover: apply A=111, B=100 -> fault_code=001; separately A 100 then 001 -> fault_code=011; A=101 with B=001 together -> fault_code=001 (priority).
REQ-029 SHALL cover: hold 100/100 for 17 samples with MAX_HOLD=16 -> fault=1, fault_code=100 the cycle after the 17th sample; 16 samples then a change -> no fault.
REQ-030 SHALL cover: after a fault with FLASH_HALF=4 -> lamps 010/010 x4, 000/000 x4, 010/010 x4 while inputs toggle; rst during an off phase -> next cycle lamps 100/100, fault=0, fault_code=000, then the REQ-026 sequence passes again.

Source files
------------

// File: rtl/lamp_guard.sv
// Safety guard between a two-road light sequencer and the lamp drivers:
// echoes legal requests one cycle late, latches the first fault and flashes amber.
module lamp_guard #(
    parameter int unsigned MAX_HOLD   = 16,
    parameter int unsigned FLASH_HALF = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] lightsA,
    input  logic [2:0] lightsB,
    output logic [2:0] lampsA,
    output logic [2:0] lampsB,
    output logic       fault,
    output logic [2:0] fault_code
);

    typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_FAULT} state_e;

    localparam int unsigned HOLD_W  = $clog2(MAX_HOLD + 2);
    localparam int unsigned FLASH_W = $clog2(2 * FLASH_HALF);

    localparam logic [HOLD_W-1:0]  HOLD_SAT     = HOLD_W'(MAX_HOLD + 1);
    localparam logic [FLASH_W-1:0] FLASH_LAST   = FLASH_W'(2 * FLASH_HALF - 1);
    localparam logic [FLASH_W-1:0] FLASH_HALF_C = FLASH_W'(FLASH_HALF);

    localparam logic [2:0] L_RED   = 3'b100;
    localparam logic [2:0] L_RA    = 3'b110;
    localparam logic [2:0] L_GREEN = 3'b001;
    localparam logic [2:0] L_AMBER = 3'b010;
    localparam logic [2:0] L_OFF   = 3'b000;

    localparam logic [2:0] C_NONE    = 3'b000;
    localparam logic [2:0] C_PATTERN = 3'b001;
    localparam logic [2:0] C_CONFL   = 3'b010;
    localparam logic [2:0] C_TRANS   = 3'b011;
    localparam logic [2:0] C_STUCK   = 3'b100;

    state_e             state_q, state_d;
    logic [2:0]         lamps_a_q, lamps_a_d;
    logic [2:0]         lamps_b_q, lamps_b_d;
    logic [2:0]         prev_a_q, prev_a_d;
    logic [2:0]         prev_b_q, prev_b_d;
    logic               fault_q, fault_d;
    logic [2:0]         code_q, code_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [FLASH_W-1:0] flash_q, flash_d;

    logic [HOLD_W-1:0]  hold_now;
    logic [FLASH_W-1:0] flash_nxt;
    logic               det_pattern, det_conflict, det_trans, det_stuck;
    logic [2:0]         det_code;

    function automatic logic pat_legal(input logic [2:0] p);
        case (p)
            L_RED, L_RA, L_GREEN, L_AMBER: return 1'b1;
            default:                       return 1'b0;
        endcase
    endfunction

    function automatic logic step_legal(input logic [2:0] prev, input logic [2:0] cur);
        if (prev == cur) return 1'b1;
        case (prev)
            L_RED:   return cur == L_RA;
            L_RA:    return cur == L_GREEN;
            L_GREEN: return cur == L_AMBER;
            L_AMBER: return cur == L_RED;
            default: return 1'b0;
        endcase
    endfunction

    // Hold count for the current sample; restarts at 1 in INIT or on any change.
    always_comb begin
        hold_now = HOLD_W'(1);
        if (state_q == ST_RUN && lightsA == prev_a_q && lightsB == prev_b_q) begin
            hold_now = (hold_q == HOLD_SAT) ? HOLD_SAT : hold_q + 1'b1;
        end
    end

    always_comb begin
        det_pattern  = !pat_legal(lightsA) || !pat_legal(lightsB);
        det_conflict = (lightsA != L_RED) && (lightsB != L_RED);
        det_trans    = (state_q == ST_RUN) &&
                       (!step_legal(prev_a_q, lightsA) || !step_legal(prev_b_q, lightsB));
        det_stuck    = (hold_now == HOLD_SAT);
        if      (det_pattern)  det_code = C_PATTERN;
        else if (det_conflict) det_code = C_CONFL;
        else if (det_trans)    det_code = C_TRANS;
        else if (det_stuck)    det_code = C_STUCK;
        else                   det_code = C_NONE;
    end

    always_comb begin
        flash_nxt = (flash_q == FLASH_LAST) ? '0 : flash_q + 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        lamps_a_d = lamps_a_q;
        lamps_b_d = lamps_b_q;
        prev_a_d  = prev_a_q;
        prev_b_d  = prev_b_q;
        fault_d   = fault_q;
        code_d    = code_q;
        hold_d    = hold_q;
        flash_d   = flash_q;
        case (state_q)
            ST_INIT, ST_RUN: begin
                hold_d   = hold_now;
                prev_a_d = lightsA;
                prev_b_d = lightsB;
                if (det_code != C_NONE) begin
                    state_d   = ST_FAULT;
                    fault_d   = 1'b1;
                    code_d    = det_code;
                    lamps_a_d = L_AMBER;
                    lamps_b_d = L_AMBER;
                    flash_d   = '0;
                end else begin
                    state_d   = ST_RUN;
                    lamps_a_d = lightsA;
                    lamps_b_d = lightsB;
                end
            end
            ST_FAULT: begin
                flash_d   = flash_nxt;
                lamps_a_d = (flash_nxt < FLASH_HALF_C) ? L_AMBER : L_OFF;
                lamps_b_d = (flash_nxt < FLASH_HALF_C) ? L_AMBER : L_OFF;
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_INIT;
            lamps_a_q <= L_RED;
            lamps_b_q <= L_RED;
            prev_a_q  <= '0;
            prev_b_q  <= '0;
            fault_q   <= 1'b0;
            code_q    <= C_NONE;
            hold_q    <= '0;
            flash_q   <= '0;
        end else begin
            state_q   <= state_d;
            lamps_a_q <= lamps_a_d;
            lamps_b_q <= lamps_b_d;
            prev_a_q  <= prev_a_d;
            prev_b_q  <= prev_b_d;
            fault_q   <= fault_d;
            code_q    <= code_d;
            hold_q    <= hold_d;
            flash_q   <= flash_d;
        end
    end

    assign lampsA     = lamps_a_q;
    assign lampsB     = lamps_b_q;
    assign fault      = fault_q;
    assign fault_code = code_q;

endmodule

// File: tb/tb_lamp_guard.sv
// Bench for lamp_guard: directed scenarios plus random traffic against a
// rule-level reference model of the guard.
module tb_lamp_guard;

    localparam int unsigned MAX_HOLD   = 16;
    localparam int unsigned FLASH_HALF = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] lightsA = 3'b100;
    logic [2:0] lightsB = 3'b100;
    logic [2:0] lampsA, lampsB, fault_code;
    logic       fault;

    always #5 clk = ~clk;

    lamp_guard #(.MAX_HOLD(MAX_HOLD), .FLASH_HALF(FLASH_HALF)) dut (
        .clk(clk), .rst(rst), .lightsA(lightsA), .lightsB(lightsB),
        .lampsA(lampsA), .lampsB(lampsB), .fault(fault), .fault_code(fault_code)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: mode 0 = no prior sample, 1 = running, 2 = faulted.
    int         m_mode = 0;
    int         m_hold = 0;
    int         m_age  = 0;
    logic [2:0] m_pa = 3'b000, m_pb = 3'b000;
    logic [2:0] exp_la = 3'b100, exp_lb = 3'b100, exp_code = 3'b000;
    logic       exp_fault = 1'b0;

    logic [2:0] seq_a [10] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b110,
                               3'b001, 3'b010, 3'b100, 3'b100, 3'b100};
    logic [2:0] seq_b [10] = '{3'b110, 3'b001, 3'b010, 3'b100, 3'b100,
                               3'b100, 3'b100, 3'b100, 3'b100, 3'b100};
    logic [2:0] ring  [4]  = '{3'b100, 3'b110, 3'b001, 3'b010};

    function automatic bit is_legal(input logic [2:0] p);
        return p inside {3'b100, 3'b110, 3'b001, 3'b010};
    endfunction

    function automatic int phase_of(input logic [2:0] p);
        case (p)
            3'b100:  return 0;
            3'b110:  return 1;
            3'b001:  return 2;
            3'b010:  return 3;
            default: return -1;
        endcase
    endfunction

    function automatic bit step_ok(input logic [2:0] prev, input logic [2:0] cur);
        return (prev == cur) || (phase_of(cur) == (phase_of(prev) + 1) % 4);
    endfunction

    task automatic model_step(input logic r, input logic [2:0] a, input logic [2:0] b);
        int code;
        if (r) begin
            m_mode = 0; m_hold = 0; m_age = 0;
            exp_la = 3'b100; exp_lb = 3'b100; exp_fault = 1'b0; exp_code = 3'b000;
        end else if (m_mode == 2) begin
            m_age++;
            exp_la = ((m_age / FLASH_HALF) % 2 == 0) ? 3'b010 : 3'b000;
            exp_lb = exp_la;
        end else begin
            m_hold = (m_mode == 1 && a == m_pa && b == m_pb) ? m_hold + 1 : 1;
            if (!is_legal(a) || !is_legal(b))                              code = 1;
            else if (a != 3'b100 && b != 3'b100)                           code = 2;
            else if (m_mode == 1 && (!step_ok(m_pa, a) || !step_ok(m_pb, b))) code = 3;
            else if (m_hold > MAX_HOLD)                                    code = 4;
            else                                                           code = 0;
            if (code != 0) begin
                m_mode = 2; m_age = 0;
                exp_fault = 1'b1; exp_code = 3'(code);
                exp_la = 3'b010; exp_lb = 3'b010;
            end else begin
                m_mode = 1; m_pa = a; m_pb = b;
                exp_la = a; exp_lb = b;
            end
        end
    endtask

    task automatic cycle(input logic r, input logic [2:0] a, input logic [2:0] b);
        rst = r; lightsA = a; lightsB = b;
        @(posedge clk);
        model_step(r, a, b);
        #1;
    endtask

    task automatic test_reset();
        cycle(1'b1, 3'b111, 3'b000);
        tests_run++;
        if ({lampsA, lampsB, fault, fault_code} !== {3'b100, 3'b100, 1'b0, 3'b000}) begin
            tests_failed++;
            $display("FAIL reset: got %b/%b f=%b c=%b want 100/100 f=0 c=000",
                     lampsA, lampsB, fault, fault_code);
        end
    endtask

    task automatic test_normal_sequence(input int reps);
        for (int r = 0; r < reps; r++) begin
            for (int i = 0; i < 10; i++) begin
                cycle(1'b0, seq_a[i], seq_b[i]);
                tests_run++;
                if ({lampsA, lampsB, fault, fault_code} !== {seq_a[i], seq_b[i], 1'b0, 3'b000}) begin
                    tests_failed++;
                    $display("FAIL normal[%0d.%0d]: got %b/%b f=%b c=%b want %b/%b f=0 c=000",
                             r, i, lampsA, lampsB, fault, fault_code, seq_a[i], seq_b[i]);
                end
            end
        end
    endtask

    task automatic test_conflict();
        cycle(1'b1, 3'b100, 3'b100);
        cycle(1'b0, 3'b100, 3'b100);
        cycle(1'b0, 3'b001, 3'b001);
        tests_run++;
        if ({lampsA, lampsB, fault, fault_code} !== {3'b010, 3'b010, 1'b1, 3'b010}) begin
            tests_failed++;
            $display("FAIL conflict: got %b/%b f=%b c=%b want 010/010 f=1 c=010",
                     lampsA, lampsB, fault, fault_code);
        end
    endtask

    task automatic test_pattern_and_transition();
        logic [2:0] fa [3] = '{3'b111, 3'b001, 3'b101};
        logic [2:0] fb [3] = '{3'b100, 3'b100, 3'b001};
        logic [2:0] fc [3] = '{3'b001, 3'b011, 3'b001};
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 3'b100, 3'b100);
            cycle(1'b0, 3'b100, 3'b100);
            cycle(1'b0, fa[i], fb[i]);
            tests_run++;
            if ({lampsA, lampsB, fault, fault_code} !== {3'b010, 3'b010, 1'b1, fc[i]}) begin
                tests_failed++;
                $display("FAIL detect[%0d]: got %b/%b f=%b c=%b want 010/010 f=1 c=%b",
                         i, lampsA, lampsB, fault, fault_code, fc[i]);
            end
            // Fault stays latched whatever follows.
            cycle(1'b0, 3'b100, 3'b100);
            tests_run++;
            if ({fault, fault_code} !== {1'b1, fc[i]}) begin
                tests_failed++;
                $display("FAIL sticky[%0d]: got f=%b c=%b want f=1 c=%b", i, fault, fault_code, fc[i]);
            end
        end
    endtask

    task automatic test_stuck();
        cycle(1'b1, 3'b100, 3'b100);
        cycle(1'b0, 3'b100, 3'b010);
        for (int i = 1; i <= MAX_HOLD + 1; i++) begin
            cycle(1'b0, 3'b100, 3'b100);
            tests_run++;
            if (i <= MAX_HOLD) begin
                if ({lampsA, lampsB, fault, fault_code} !== {3'b100, 3'b100, 1'b0, 3'b000}) begin
                    tests_failed++;
                    $display("FAIL stuck_hold[%0d]: got %b/%b f=%b c=%b want 100/100 f=0 c=000",
                             i, lampsA, lampsB, fault, fault_code);
                end
            end else if ({lampsA, lampsB, fault, fault_code} !== {3'b010, 3'b010, 1'b1, 3'b100}) begin
                tests_failed++;
                $display("FAIL stuck_trip: got %b/%b f=%b c=%b want 010/010 f=1 c=100",
                         lampsA, lampsB, fault, fault_code);
            end
        end
        cycle(1'b1, 3'b100, 3'b100);
        cycle(1'b0, 3'b100, 3'b010);
        for (int i = 0; i < MAX_HOLD; i++) cycle(1'b0, 3'b100, 3'b100);
        cycle(1'b0, 3'b100, 3'b110);
        tests_run++;
        if ({lampsA, lampsB, fault, fault_code} !== {3'b100, 3'b110, 1'b0, 3'b000}) begin
            tests_failed++;
            $display("FAIL stuck_edge: got %b/%b f=%b c=%b want 100/110 f=0 c=000",
                     lampsA, lampsB, fault, fault_code);
        end
    endtask

    task automatic test_flash_and_reset();
        logic [2:0] want;
        cycle(1'b1, 3'b100, 3'b100);
        cycle(1'b0, 3'b100, 3'b100);
        cycle(1'b0, 3'b001, 3'b001);
        for (int k = 0; k < 14; k++) begin
            if (k > 0) cycle(1'b0, 3'($urandom), 3'($urandom));
            want = ((k / FLASH_HALF) % 2 == 0) ? 3'b010 : 3'b000;
            tests_run++;
            if ({lampsA, lampsB, fault, fault_code} !== {want, want, 1'b1, 3'b010}) begin
                tests_failed++;
                $display("FAIL flash[%0d]: got %b/%b f=%b c=%b want %b/%b f=1 c=010",
                         k, lampsA, lampsB, fault, fault_code, want, want);
            end
        end
        cycle(1'b1, 3'b001, 3'b001);
        tests_run++;
        if ({lampsA, lampsB, fault, fault_code} !== {3'b100, 3'b100, 1'b0, 3'b000}) begin
            tests_failed++;
            $display("FAIL flash_reset: got %b/%b f=%b c=%b want 100/100 f=0 c=000",
                     lampsA, lampsB, fault, fault_code);
        end
        test_normal_sequence(1);
    endtask

    task automatic test_random();
        logic [2:0] ga, gb;
        logic       r;
        int         pa, pb, sel;
        for (int ep = 0; ep < 40; ep++) begin
            cycle(1'b1, 3'b100, 3'b100);
            pa = 0; pb = 0;
            for (int c = 0; c < 25; c++) begin
                sel = $urandom_range(0, 15);
                if (sel >= 10 && sel < 14) pa = (pa + 1) % 4;
                ga = (sel >= 14) ? 3'($urandom) : ring[pa];
                sel = $urandom_range(0, 15);
                if (sel >= 10 && sel < 14) pb = (pb + 1) % 4;
                gb = (sel >= 14) ? 3'($urandom) : ring[pb];
                r = ($urandom_range(0, 63) == 0);
                cycle(r, ga, gb);
                tests_run++;
                if ({lampsA, lampsB, fault, fault_code} !== {exp_la, exp_lb, exp_fault, exp_code}) begin
                    tests_failed++;
                    $display("FAIL random[%0d.%0d] in=%b/%b rst=%b: got %b/%b f=%b c=%b want %b/%b f=%b c=%b",
                             ep, c, ga, gb, r, lampsA, lampsB, fault, fault_code,
                             exp_la, exp_lb, exp_fault, exp_code);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_normal_sequence(3);
        test_conflict();
        test_pattern_and_transition();
        test_stuck();
        test_flash_and_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
